// File: rtl/y86_pkg.sv
// Shared encodings for the Y86-64 fetch/decode/execute slice: opcodes, ALU
// functions, condition functions, special register numbers and CC bit positions.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fn_e;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] REG_NONE = 4'hF;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    function automatic logic need_regids(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ:  return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic need_valc(input logic [3:0] icode);
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_fetch_decode_execute_if.sv
// Bus between the instruction/data-memory side (master) and the
// fetch/decode/execute block (slave), including the live register-file view.
interface y86_fetch_decode_execute_if;

    logic [63:0] PC;
    logic [79:0] instr;
    logic [63:0] valM;

    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, valA, valB, valE;
    logic        cnd;
    logic [2:0]  CC_out;
    logic        instr_valid, imem_error;

    logic [63:0] reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4;
    logic [63:0] reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9;
    logic [63:0] reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14;

    modport master (
        output PC, instr, valM,
        input  icode, ifun, rA, rB, valC, valP, valA, valB, valE, cnd, CC_out,
               instr_valid, imem_error,
               reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4,
               reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9,
               reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14
    );

    modport slave (
        input  PC, instr, valM,
        output icode, ifun, rA, rB, valC, valP, valA, valB, valE, cnd, CC_out,
               instr_valid, imem_error,
               reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4,
               reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9,
               reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14
    );

endinterface

// File: rtl/y86_alu.sv
// 64-bit Y86 ALU: add, sub (b - a), and, xor, with {ZF,SF,OF} flag generation.
module y86_alu
    import y86_pkg::*;
(
    input  logic [63:0] alu_a,
    input  logic [63:0] alu_b,
    input  alu_fn_e     alu_fn,
    output logic [63:0] val_e,
    output logic [2:0]  cc
);

    logic of;

    always_comb begin
        val_e = '0;
        of    = 1'b0;
        unique case (alu_fn)
            ALU_ADD: begin
                val_e = alu_b + alu_a;
                of    = (alu_a[63] == alu_b[63]) && (val_e[63] != alu_a[63]);
            end
            ALU_SUB: begin
                val_e = alu_b - alu_a;
                of    = (alu_a[63] != alu_b[63]) && (val_e[63] != alu_b[63]);
            end
            ALU_AND: val_e = alu_b & alu_a;
            ALU_XOR: val_e = alu_b ^ alu_a;
        endcase
        cc        = '0;
        cc[CC_ZF] = (val_e == 64'd0);
        cc[CC_SF] = val_e[63];
        cc[CC_OF] = of;
    end

endmodule

// File: rtl/y86_fetch_decode_execute.sv
// Sequential Y86-64 fetch, decode/write-back and execute stages with register file
// and CC register. Define Y86_TRACE_EN for a per-cycle simulation trace.
module y86_fetch_decode_execute #(
    parameter int IMEM_BYTES = 20481
) (
    input logic                        clk,
    input logic                        rst,
    y86_fetch_decode_execute_if.slave  bus
);
    import y86_pkg::*;

    logic [7:0]  ibyte [10];
    logic [3:0]  icode, ifun, ra, rb;
    logic        need_regs, need_const;
    logic [63:0] valc, valp, ilen;
    logic [64:0] fetch_end;
    logic        instr_valid, imem_error;

    always_comb begin
        for (int i = 0; i < 10; i++) begin
            ibyte[i] = bus.instr[79 - 8*i -: 8];
        end
    end

    assign icode      = ibyte[0][7:4];
    assign ifun       = ibyte[0][3:0];
    assign need_regs  = need_regids(icode);
    assign need_const = need_valc(icode);
    assign ra         = need_regs ? ibyte[1][7:4] : REG_NONE;
    assign rb         = need_regs ? ibyte[1][3:0] : REG_NONE;

    // The constant is little-endian and starts after the register byte if present.
    always_comb begin
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:
                valc = {ibyte[9], ibyte[8], ibyte[7], ibyte[6],
                        ibyte[5], ibyte[4], ibyte[3], ibyte[2]};
            I_JXX, I_CALL:
                valc = {ibyte[8], ibyte[7], ibyte[6], ibyte[5],
                        ibyte[4], ibyte[3], ibyte[2], ibyte[1]};
            default:
                valc = '0;
        endcase
    end

    assign ilen        = 64'd1 + {63'd0, need_regs} + (need_const ? 64'd8 : 64'd0);
    assign valp        = bus.PC + ilen;
    assign instr_valid = (icode <= I_POPQ);
    assign fetch_end   = {1'b0, bus.PC} + {1'b0, ilen};
    assign imem_error  = (fetch_end > 65'(IMEM_BYTES));

    logic [63:0] regs_q [15];
    logic [63:0] regs_d [15];
    logic [2:0]  cc_q, cc_d;
    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] val_a, val_b;

    always_comb begin
        src_a = REG_NONE;
        src_b = REG_NONE;
        case (icode)
            I_RRMOVQ:           src_a = ra;
            I_RMMOVQ, I_OPQ:    begin src_a = ra; src_b = rb; end
            I_MRMOVQ:           src_b = rb;
            I_CALL:             src_b = REG_RSP;
            I_RET, I_POPQ:      begin src_a = REG_RSP; src_b = REG_RSP; end
            I_PUSHQ:            begin src_a = ra; src_b = REG_RSP; end
            default: ;
        endcase
    end

    assign val_a = (src_a == REG_NONE) ? 64'd0 : regs_q[src_a];
    assign val_b = (src_b == REG_NONE) ? 64'd0 : regs_q[src_b];

    logic [63:0] alu_a, alu_b, val_e;
    logic [2:0]  cc_out;
    alu_fn_e     alu_fn;

    always_comb begin
        case (icode)
            I_RRMOVQ, I_OPQ:              alu_a = val_a;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = valc;
            I_CALL, I_PUSHQ:              alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            I_RET, I_POPQ:                alu_a = 64'd8;
            default:                      alu_a = '0;
        endcase
        alu_b  = (icode == I_RRMOVQ || icode == I_IRMOVQ) ? 64'd0 : val_b;
        alu_fn = ALU_ADD;
        if (icode == I_OPQ && ifun <= 4'd3) begin
            alu_fn = alu_fn_e'(ifun[1:0]);
        end
    end

    y86_alu u_alu (
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_fn (alu_fn),
        .val_e  (val_e),
        .cc     (cc_out)
    );

    logic cond_true, cnd, sf_ne_of;

    // Conditions look at the CC register before this instruction's own update.
    always_comb begin
        sf_ne_of = cc_q[CC_SF] ^ cc_q[CC_OF];
        case (ifun)
            C_YES:   cond_true = 1'b1;
            C_LE:    cond_true = sf_ne_of | cc_q[CC_ZF];
            C_L:     cond_true = sf_ne_of;
            C_E:     cond_true = cc_q[CC_ZF];
            C_NE:    cond_true = ~cc_q[CC_ZF];
            C_GE:    cond_true = ~sf_ne_of;
            C_G:     cond_true = ~sf_ne_of & ~cc_q[CC_ZF];
            default: cond_true = 1'b0;
        endcase
        cnd = (icode == I_RRMOVQ || icode == I_JXX) && cond_true;
    end

    always_comb begin
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        case (icode)
            I_RRMOVQ:                        dst_e = cnd ? rb : REG_NONE;
            I_IRMOVQ, I_OPQ:                 dst_e = rb;
            I_CALL, I_RET, I_PUSHQ:          dst_e = REG_RSP;
            I_POPQ:                          begin dst_e = REG_RSP; dst_m = ra; end
            I_MRMOVQ:                        dst_m = ra;
            default: ;
        endcase
    end

    // The M write is applied last so a popq into %rsp keeps the loaded value.
    always_comb begin
        regs_d = regs_q;
        if (instr_valid && !imem_error) begin
            if (dst_e != REG_NONE) regs_d[dst_e] = val_e;
            if (dst_m != REG_NONE) regs_d[dst_m] = bus.valM;
        end
        cc_d = cc_q;
        if (icode == I_OPQ && instr_valid) begin
            cc_d = cc_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= '0;
            cc_q <= 3'b100;
        end else begin
            for (int i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
            cc_q <= cc_d;
        end
    end

    assign bus.icode       = icode;
    assign bus.ifun        = ifun;
    assign bus.rA          = ra;
    assign bus.rB          = rb;
    assign bus.valC        = valc;
    assign bus.valP        = valp;
    assign bus.valA        = val_a;
    assign bus.valB        = val_b;
    assign bus.valE        = val_e;
    assign bus.cnd         = cnd;
    assign bus.CC_out      = cc_out;
    assign bus.instr_valid = instr_valid;
    assign bus.imem_error  = imem_error;
    assign bus.reg_mem0    = regs_q[0];
    assign bus.reg_mem1    = regs_q[1];
    assign bus.reg_mem2    = regs_q[2];
    assign bus.reg_mem3    = regs_q[3];
    assign bus.reg_mem4    = regs_q[4];
    assign bus.reg_mem5    = regs_q[5];
    assign bus.reg_mem6    = regs_q[6];
    assign bus.reg_mem7    = regs_q[7];
    assign bus.reg_mem8    = regs_q[8];
    assign bus.reg_mem9    = regs_q[9];
    assign bus.reg_mem10   = regs_q[10];
    assign bus.reg_mem11   = regs_q[11];
    assign bus.reg_mem12   = regs_q[12];
    assign bus.reg_mem13   = regs_q[13];
    assign bus.reg_mem14   = regs_q[14];

`ifdef Y86_TRACE_EN
    always @(posedge clk) begin
        if (!rst) begin
            $display("Y86 PC=%h icode=%h ifun=%h valA=%h valB=%h valE=%h cnd=%b CC=%b",
                     bus.PC, icode, ifun, val_a, val_b, val_e, cnd, cc_q);
        end
    end
`else
`endif

endmodule

// File: tb/tb_y86_fetch_decode_execute.sv
// Self-checking bench: directed Y86 sequences with literal expectations, then
// randomized instructions compared every cycle against an instruction-level model.
module tb_y86_fetch_decode_execute;

    localparam int IMEM_BYTES = 20481;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;

    y86_fetch_decode_execute_if bus();

    y86_fetch_decode_execute #(.IMEM_BYTES(IMEM_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] dut_regs [15];
    assign dut_regs[0]  = bus.reg_mem0;
    assign dut_regs[1]  = bus.reg_mem1;
    assign dut_regs[2]  = bus.reg_mem2;
    assign dut_regs[3]  = bus.reg_mem3;
    assign dut_regs[4]  = bus.reg_mem4;
    assign dut_regs[5]  = bus.reg_mem5;
    assign dut_regs[6]  = bus.reg_mem6;
    assign dut_regs[7]  = bus.reg_mem7;
    assign dut_regs[8]  = bus.reg_mem8;
    assign dut_regs[9]  = bus.reg_mem9;
    assign dut_regs[10] = bus.reg_mem10;
    assign dut_regs[11] = bus.reg_mem11;
    assign dut_regs[12] = bus.reg_mem12;
    assign dut_regs[13] = bus.reg_mem13;
    assign dut_regs[14] = bus.reg_mem14;

    // Architectural state of the model and its expectations for the current instruction
    logic [63:0] regs_m [15];
    logic [2:0]  cc_m;
    logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
    logic [63:0] e_valc, e_valp, e_vala, e_valb, e_vale;
    logic        e_cnd, e_valid, e_imem;
    logic [2:0]  e_ccout;
    logic        p_rst, p_wb, p_cc_en;
    logic [3:0]  p_e_idx, p_m_idx;
    logic [63:0] p_e_val, p_m_val;
    logic [2:0]  p_cc;

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] le64(input logic [63:0] c);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[63 - 8*k -: 8] = c[8*k +: 8];
        return r;
    endfunction

    function automatic logic [79:0] f_rr(input logic [7:0] b0, input logic [7:0] b1);
        return {b0, b1, 64'h0};
    endfunction

    function automatic logic [79:0] f_ir(input logic [7:0] b0, input logic [7:0] b1, input logic [63:0] c);
        return {b0, b1, le64(c)};
    endfunction

    function automatic logic [63:0] rd(input logic [3:0] idx);
        return (idx == 4'hF) ? 64'd0 : regs_m[idx];
    endfunction

    // Instruction-level model: lengths, operand routing and flags from the ISA rules
    task automatic predict(input logic [63:0] pc, input logic [79:0] ins, input logic [63:0] vm, input logic r);
        logic [7:0]  bt [10];
        int          len, start;
        logic [63:0] a_op, b_op, res;
        logic [64:0] wide;
        logic [3:0]  sa, sb;
        logic        zf, sf, of, take;
        for (int k = 0; k < 10; k++) bt[k] = ins[79 - 8*k -: 8];
        e_icode = bt[0][7:4];
        e_ifun  = bt[0][3:0];
        case (e_icode)
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h3, 4'h4, 4'h5:       len = 10;
            4'h7, 4'h8:             len = 9;
            default:                len = 1;
        endcase
        e_ra   = (len == 2 || len == 10) ? bt[1][7:4] : 4'hF;
        e_rb   = (len == 2 || len == 10) ? bt[1][3:0] : 4'hF;
        e_valc = 64'd0;
        start  = (len == 10) ? 2 : 1;
        if (len >= 9) for (int j = 7; j >= 0; j--) e_valc = {e_valc[55:0], bt[start + j]};
        e_valp  = pc + 64'(len);
        e_valid = (e_icode <= 4'hB);
        e_imem  = ({1'b0, pc} + 65'(len)) > 65'(IMEM_BYTES);
        case (e_icode)
            4'h2, 4'h4, 4'h6, 4'hA: sa = e_ra;
            4'h9, 4'hB:             sa = 4'h4;
            default:                sa = 4'hF;
        endcase
        case (e_icode)
            4'h4, 4'h5, 4'h6:       sb = e_rb;
            4'h8, 4'h9, 4'hA, 4'hB: sb = 4'h4;
            default:                sb = 4'hF;
        endcase
        e_vala = rd(sa);
        e_valb = rd(sb);
        case (e_icode)
            4'h2, 4'h6:       a_op = e_vala;
            4'h3, 4'h4, 4'h5: a_op = e_valc;
            4'h8, 4'hA:       a_op = -64'd8;
            4'h9, 4'hB:       a_op = 64'd8;
            default:          a_op = 64'd0;
        endcase
        b_op = (e_icode == 4'h2 || e_icode == 4'h3) ? 64'd0 : e_valb;
        of = 1'b0;
        if (e_icode == 4'h6 && e_ifun == 4'h1) begin
            wide = {b_op[63], b_op} - {a_op[63], a_op};
            res  = wide[63:0];
            of   = wide[64] ^ wide[63];
        end else if (e_icode == 4'h6 && e_ifun == 4'h2) begin
            res = a_op & b_op;
        end else if (e_icode == 4'h6 && e_ifun == 4'h3) begin
            res = a_op ^ b_op;
        end else begin
            wide = {b_op[63], b_op} + {a_op[63], a_op};
            res  = wide[63:0];
            of   = wide[64] ^ wide[63];
        end
        zf = (res == 64'd0);
        sf = res[63];
        e_vale  = res;
        e_ccout = {zf, sf, of};
        case (e_ifun)
            4'h0: take = 1'b1;
            4'h1: take = (cc_m[1] != cc_m[0]) || cc_m[2];
            4'h2: take = (cc_m[1] != cc_m[0]);
            4'h3: take = cc_m[2];
            4'h4: take = !cc_m[2];
            4'h5: take = (cc_m[1] == cc_m[0]);
            4'h6: take = (cc_m[1] == cc_m[0]) && !cc_m[2];
            default: take = 1'b0;
        endcase
        e_cnd = (e_icode == 4'h2 || e_icode == 4'h7) && take;
        p_rst = r;
        p_wb  = e_valid && !e_imem;
        case (e_icode)
            4'h2:                   p_e_idx = take ? e_rb : 4'hF;
            4'h3, 4'h6:             p_e_idx = e_rb;
            4'h8, 4'h9, 4'hA, 4'hB: p_e_idx = 4'h4;
            default:                p_e_idx = 4'hF;
        endcase
        p_m_idx = (e_icode == 4'h5 || e_icode == 4'hB) ? e_ra : 4'hF;
        p_e_val = res;
        p_m_val = vm;
        p_cc_en = (e_icode == 4'h6) && e_valid;
        p_cc    = e_ccout;
    endtask

    task automatic applyStimulus(input logic [63:0] pc, input logic [79:0] ins, input logic [63:0] vm, input logic r);
        rst       = r;
        bus.PC    = pc;
        bus.instr = ins;
        bus.valM  = vm;
        predict(pc, ins, vm, r);
    endtask

    task automatic stepClock();
        @(posedge clk);
        if (p_rst) begin
            for (int i = 0; i < 15; i++) regs_m[i] = 64'd0;
            cc_m = 3'b100;
        end else begin
            if (p_wb) begin
                if (p_e_idx != 4'hF) regs_m[p_e_idx] = p_e_val;
                if (p_m_idx != 4'hF) regs_m[p_m_idx] = p_m_val;
            end
            if (p_cc_en) cc_m = p_cc;
        end
        #1;
    endtask

    task automatic checkOutput();
        check64("icode", bus.icode, e_icode);
        check64("ifun", bus.ifun, e_ifun);
        check64("rA", bus.rA, e_ra);
        check64("rB", bus.rB, e_rb);
        check64("valC", bus.valC, e_valc);
        check64("valP", bus.valP, e_valp);
        check64("valA", bus.valA, e_vala);
        check64("valB", bus.valB, e_valb);
        check64("valE", bus.valE, e_vale);
        check64("cnd", bus.cnd, e_cnd);
        check64("CC_out", bus.CC_out, e_ccout);
        check64("instr_valid", bus.instr_valid, e_valid);
        check64("imem_error", bus.imem_error, e_imem);
        for (int i = 0; i < 15; i++) check64($sformatf("reg_mem%0d", i), dut_regs[i], regs_m[i]);
    endtask

    always @(negedge clk) begin
        if (check_en) checkOutput();
    end

    initial begin
        logic [79:0] ins;
        logic [63:0] pc;
        int          ic, fn;
        for (int i = 0; i < 15; i++) regs_m[i] = 64'd0;
        cc_m = 3'b100;

        applyStimulus(64'd0, f_rr(8'h10, 8'h00), 64'd0, 1'b1);
        stepClock();
        check_en = 1'b1;
        applyStimulus(64'd0, f_rr(8'h10, 8'h00), 64'd0, 1'b1);
        stepClock();
        check64("reset_rdx", bus.reg_mem2, 64'd0);

        applyStimulus(64'd0, f_ir(8'h30, 8'hF2, 64'd5), 64'd0, 1'b0);
        #1;
        check64("irmovq_valC", bus.valC, 64'd5);
        check64("irmovq_valP", bus.valP, 64'd10);
        check64("irmovq_valE", bus.valE, 64'd5);
        stepClock();
        check64("irmovq_wb", bus.reg_mem2, 64'd5);

        applyStimulus(64'd10, {8'h73, le64(64'h40), 8'h00}, 64'd0, 1'b0);
        #1;
        check64("je_after_reset_cnd", bus.cnd, 64'd1);
        stepClock();

        applyStimulus(64'd19, f_ir(8'h30, 8'hF3, 64'd3), 64'd0, 1'b0);
        stepClock();
        applyStimulus(64'd29, f_ir(8'h30, 8'hF5, 64'd7), 64'd0, 1'b0);
        stepClock();

        applyStimulus(64'd39, f_rr(8'h61, 8'h23), 64'd0, 1'b0);
        #1;
        check64("subq_valE", bus.valE, 64'hFFFF_FFFF_FFFF_FFFE);
        check64("subq_CC_out", bus.CC_out, 64'b010);
        stepClock();
        check64("subq_wb", bus.reg_mem3, 64'hFFFF_FFFF_FFFF_FFFE);

        applyStimulus(64'd41, f_rr(8'h25, 8'h53), 64'd0, 1'b0);
        #1;
        check64("cmovge_cnd", bus.cnd, 64'd0);
        stepClock();
        check64("cmovge_nowrite", bus.reg_mem3, 64'hFFFF_FFFF_FFFF_FFFE);

        applyStimulus(64'd43, f_rr(8'h63, 8'h00), 64'd0, 1'b0);
        #1;
        check64("xorq_CC_out", bus.CC_out, 64'b100);
        stepClock();

        applyStimulus(64'd45, f_rr(8'h21, 8'h53), 64'd0, 1'b0);
        #1;
        check64("cmovle_cnd", bus.cnd, 64'd1);
        stepClock();
        check64("cmovle_wb", bus.reg_mem3, 64'd7);

        applyStimulus(64'd47, f_ir(8'h30, 8'hF1, 64'h7FFF_FFFF_FFFF_FFFF), 64'd0, 1'b0);
        stepClock();
        applyStimulus(64'd57, f_ir(8'h30, 8'hF6, 64'd1), 64'd0, 1'b0);
        stepClock();
        applyStimulus(64'd67, f_rr(8'h60, 8'h61), 64'd0, 1'b0);
        #1;
        check64("addq_ovf_valE", bus.valE, 64'h8000_0000_0000_0000);
        check64("addq_ovf_CC_out", bus.CC_out, 64'b011);
        stepClock();

        applyStimulus(64'd69, f_ir(8'h30, 8'hF4, 64'h100), 64'd0, 1'b0);
        stepClock();
        applyStimulus(64'd79, f_rr(8'hA0, 8'h0F), 64'd0, 1'b0);
        #1;
        check64("pushq_valE", bus.valE, 64'hF8);
        stepClock();
        check64("pushq_rsp", bus.reg_mem4, 64'hF8);

        applyStimulus(64'd81, f_rr(8'hB0, 8'h0F), 64'h55, 1'b0);
        stepClock();
        check64("popq_rax", bus.reg_mem0, 64'h55);
        check64("popq_rsp", bus.reg_mem4, 64'h100);

        applyStimulus(64'd83, f_rr(8'hB0, 8'h4F), 64'h1234, 1'b0);
        stepClock();
        check64("popq_rsp_mwins", bus.reg_mem4, 64'h1234);

        applyStimulus(64'd85, {8'hC0, 8'h12, 64'h0}, 64'd0, 1'b0);
        #1;
        check64("invalid_instr_valid", bus.instr_valid, 64'd0);
        stepClock();

        applyStimulus(64'(IMEM_BYTES - 2), f_ir(8'h30, 8'hF2, 64'd99), 64'd0, 1'b0);
        #1;
        check64("imem_error_flag", bus.imem_error, 64'd1);
        stepClock();
        check64("imem_error_nowrite", bus.reg_mem2, 64'd5);

        for (int n = 0; n < 400; n++) begin
            ins = {16'($urandom), $urandom, $urandom};
            ic  = int'($urandom_range(0, 13));
            if (ic == 6)                fn = int'($urandom_range(0, 3));
            else if (ic == 2 || ic == 7) fn = int'($urandom_range(0, 7));
            else                        fn = 0;
            ins[79:72] = {4'(ic), 4'(fn)};
            if ($urandom_range(0, 9) == 0) pc = 64'(IMEM_BYTES - int'($urandom_range(0, 12)));
            else                           pc = 64'($urandom_range(0, 20000));
            applyStimulus(pc, ins, {$urandom, $urandom}, (n == 200));
            stepClock();
            if (n == 200) begin
                check64("midreset_rdx", bus.reg_mem2, 64'd0);
                check64("midreset_rsp", bus.reg_mem4, 64'd0);
            end
        end

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
